dmem_access_unit: RTL and testbench

Load/store initiator that sits between the CPU execute stage and the data memory. It accepts one byte-addressed load or store request at a time over a valid/ready handshake and drives the data memory's enable, write-enable, address, data-type and write-data pins. For loads it captures the returned word and applies sign or zero extension. It returns a single response per request, flagging misaligned or out-of-range accesses without touching memory.

---
 rtl/dmem_access_unit.sv | 193 +++++++++++++++++++
 tb/tb_dmem_access_unit.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_access_unit.sv
// dmem_access_unit: single-outstanding load/store initiator between the
// execute stage and a word-organised data memory. Checks each request for
// alignment and range, runs one memory access cycle for legal requests,
// extends load data and keeps saturating load/store/error statistics.
module dmem_access_unit #(
  parameter int DEPTH = 2048,
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic [31:0]      req_addr,
  input  logic [31:0]      req_wdata,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [31:0]      resp_rdata,
  output logic             resp_error,
  output logic             mem_enable,
  output logic             mem_write_enable,
  output logic [31:0]      mem_address,
  output logic [1:0]       mem_data_type,
  output logic [31:0]      mem_input_data,
  input  logic [31:0]      mem_output_data,
  output logic [CNT_W-1:0] load_count,
  output logic [CNT_W-1:0] store_count,
  output logic [CNT_W-1:0] error_count
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    OP_LW  = 3'b000,
    OP_LH  = 3'b001,
    OP_LHU = 3'b010,
    OP_LB  = 3'b011,
    OP_LBU = 3'b100,
    OP_SW  = 3'b101,
    OP_SH  = 3'b110,
    OP_SB  = 3'b111
  } op_t;

  localparam logic [1:0] DT_WORD = 2'b00;
  localparam logic [1:0] DT_HALF = 2'b01;
  localparam logic [1:0] DT_BYTE = 2'b10;

  // First byte address past the end of memory; one extra bit so that
  // DEPTH*4 == 2^32 would still compare correctly.
  localparam logic [32:0] ADDR_LIMIT = 33'(DEPTH) * 33'd4;

  function automatic logic is_store(input op_t op);
    return (op == OP_SW) || (op == OP_SH) || (op == OP_SB);
  endfunction

  function automatic logic [1:0] data_type(input op_t op);
    case (op)
      OP_LW, OP_SW:          return DT_WORD;
      OP_LH, OP_LHU, OP_SH:  return DT_HALF;
      default:               return DT_BYTE;
    endcase
  endfunction

  function automatic logic [31:0] extend_load(input op_t op, input logic [31:0] d);
    case (op)
      OP_LB:   return {{24{d[7]}}, d[7:0]};
      OP_LBU:  return {24'h0, d[7:0]};
      OP_LH:   return {{16{d[15]}}, d[15:0]};
      OP_LHU:  return {16'h0, d[15:0]};
      default: return d;
    endcase
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  state_t            state_q, state_d;
  op_t               op_q;
  logic [29:0]       word_addr_q;   // byte offset is only needed for the check
  logic [31:0]       wdata_q;
  logic [31:0]       rdata_q;
  logic              error_q;
  logic              req_misaligned;
  logic              req_out_of_range;
  op_t               req_op_t;

  assign req_op_t = op_t'(req_op);

  // Alignment and range check of the incoming request.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the case leaves it unassigned and infers a latch.
    req_misaligned = 1'b0;
    case (req_op_t)
      OP_LW, OP_SW:         req_misaligned = |req_addr[1:0];
      OP_LH, OP_LHU, OP_SH: req_misaligned = req_addr[0];
      default:              req_misaligned = 1'b0;
    endcase
    req_out_of_range = ({1'b0, req_addr} >= ADDR_LIMIT);
  end

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic: errors skip the memory cycle and go straight to RESP.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req_valid)
          state_d = (req_misaligned || req_out_of_range) ? RESP : ACCESS;
      end
      ACCESS:  state_d = RESP;
      RESP:    if (resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request capture, load data capture and statistics.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      op_q        <= OP_LW;
      word_addr_q <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      error_q     <= 1'b0;
      load_count  <= '0;
      store_count <= '0;
      error_count <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            op_q        <= req_op_t;
            word_addr_q <= req_addr[31:2];
            wdata_q     <= req_wdata;
            rdata_q     <= '0;
            error_q     <= req_misaligned || req_out_of_range;
          end
        end
        ACCESS: begin
          if (!is_store(op_q))
            rdata_q <= extend_load(op_q, mem_output_data);
        end
        RESP: begin
          if (resp_ready) begin
            if (error_q)             error_count <= sat_inc(error_count);
            else if (is_store(op_q)) store_count <= sat_inc(store_count);
            else                     load_count  <= sat_inc(load_count);
          end
        end
        default: ;
      endcase
    end
  end

  // Handshake and memory pins, decoded from registered state only so the
  // memory sees stable values across the whole ACCESS cycle.
  always_comb begin
    req_ready        = (state_q == IDLE);
    resp_valid       = (state_q == RESP);
    resp_rdata       = (state_q == RESP) ? rdata_q : 32'h0;
    resp_error       = (state_q == RESP) && error_q;
    mem_enable       = 1'b0;
    mem_write_enable = 1'b0;
    mem_address      = 32'h0;
    mem_data_type    = DT_WORD;
    mem_input_data   = 32'h0;
    if (state_q == ACCESS) begin
      mem_enable       = 1'b1;
      mem_write_enable = is_store(op_q);
      mem_address      = {2'b00, word_addr_q};
      mem_data_type    = data_type(op_q);
      case (op_q)
        OP_SW:   mem_input_data = wdata_q;
        OP_SH:   mem_input_data = {16'h0, wdata_q[15:0]};
        OP_SB:   mem_input_data = {24'h0, wdata_q[7:0]};
        default: mem_input_data = 32'h0;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_access_unit.sv
// Testbench for dmem_access_unit: directed vector table, reset and
// back-pressure sequences, randomized requests against a byte-level
// reference model, and counter saturation on a narrow-counter instance.
module tb_dmem_access_unit;

  localparam int DEPTH = 2048;
  localparam int CNT_W = 16;

  localparam logic [2:0] LW = 3'b000, LH = 3'b001, LHU = 3'b010, LB = 3'b011,
                         LBU = 3'b100, SW = 3'b101, SH = 3'b110, SB = 3'b111;

  logic             clock = 1'b0;
  logic             reset;
  logic             req_valid, req_ready, resp_valid, resp_ready, resp_error;
  logic [2:0]       req_op;
  logic [31:0]      req_addr, req_wdata, resp_rdata;
  logic             mem_enable, mem_write_enable;
  logic [31:0]      mem_address, mem_input_data, mem_output_data;
  logic [1:0]       mem_data_type;
  logic [CNT_W-1:0] load_count, store_count, error_count;

  // Narrow-counter instance for the saturation check.
  logic        s_req_valid, s_req_ready, s_resp_valid, s_resp_ready, s_resp_error;
  logic [2:0]  s_req_op;
  logic [31:0] s_req_addr, s_req_wdata, s_resp_rdata;
  logic        s_mem_enable, s_mem_write_enable;
  logic [31:0] s_mem_address, s_mem_input_data;
  logic [31:0] s_mem_output_data = 32'h0;
  logic [1:0]  s_mem_data_type;
  logic [1:0]  s_load_count, s_store_count, s_error_count;

  int checks = 0;
  int errors = 0;
  int exp_load = 0, exp_store = 0, exp_err = 0;

  logic [31:0] mem_phys [0:DEPTH-1];  // memory driven by the DUT pins
  logic [31:0] ref_mem  [0:DEPTH-1];  // reference model's view of memory

  always #5 clock = ~clock;

  dmem_access_unit #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_error(resp_error),
    .mem_enable(mem_enable), .mem_write_enable(mem_write_enable),
    .mem_address(mem_address), .mem_data_type(mem_data_type),
    .mem_input_data(mem_input_data), .mem_output_data(mem_output_data),
    .load_count(load_count), .store_count(store_count), .error_count(error_count)
  );

  dmem_access_unit #(.DEPTH(16), .CNT_W(2)) dut_sat (
    .clock(clock), .reset(reset),
    .req_valid(s_req_valid), .req_ready(s_req_ready), .req_op(s_req_op),
    .req_addr(s_req_addr), .req_wdata(s_req_wdata),
    .resp_valid(s_resp_valid), .resp_ready(s_resp_ready),
    .resp_rdata(s_resp_rdata), .resp_error(s_resp_error),
    .mem_enable(s_mem_enable), .mem_write_enable(s_mem_write_enable),
    .mem_address(s_mem_address), .mem_data_type(s_mem_data_type),
    .mem_input_data(s_mem_input_data), .mem_output_data(s_mem_output_data),
    .load_count(s_load_count), .store_count(s_store_count), .error_count(s_error_count)
  );

  // Word memory: writes the used low lane on the falling edge, reads async.
  assign mem_output_data = mem_phys[mem_address[10:0]];
  always @(negedge clock) begin
    if (mem_enable && mem_write_enable) begin
      case (mem_data_type)
        2'b00:   mem_phys[mem_address[10:0]]        <= mem_input_data;
        2'b01:   mem_phys[mem_address[10:0]][15:0]  <= mem_input_data[15:0];
        default: mem_phys[mem_address[10:0]][7:0]   <= mem_input_data[7:0];
      endcase
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic int op_size(input logic [2:0] op);
    if (op == LW || op == SW) return 4;
    if (op == LH || op == LHU || op == SH) return 2;
    return 1;
  endfunction

  function automatic logic op_store(input logic [2:0] op);
    return op == SW || op == SH || op == SB;
  endfunction

  function automatic logic [31:0] size_mask(input int size);
    return (size == 4) ? 32'hFFFF_FFFF : (size == 2) ? 32'h0000_FFFF : 32'h0000_00FF;
  endfunction

  // Reference behaviour: alignment to access size, range against memory
  // size, low-lane store merge, masked and optionally sign-extended load.
  task automatic ref_access(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                            output logic err, output logic [31:0] rdata);
    int          size;
    logic [31:0] mask, v;
    longint      a;
    size  = op_size(op);
    mask  = size_mask(size);
    a     = longint'(addr);
    err   = (a % size != 0) || (a >= longint'(DEPTH) * 4);
    rdata = 32'h0;
    if (!err) begin
      if (op_store(op)) begin
        ref_mem[a / 4] = (ref_mem[a / 4] & ~mask) | (wdata & mask);
      end else begin
        v = ref_mem[a / 4] & mask;
        if ((op == LB || op == LH) && v[8 * size - 1]) v = v | ~mask;
        rdata = v;
      end
    end
  endtask

  // One complete request with resp_ready high; checks pins, response and counters.
  task automatic do_req(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic exp_error, input logic [31:0] exp_rdata);
    int size;
    size = op_size(op);
    check("req_ready_idle", req_ready, 1);
    req_valid = 1; req_op = op; req_addr = addr; req_wdata = wdata; resp_ready = 1;
    tick();
    req_valid = 0;
    if (exp_error) begin
      check("err_mem_enable", mem_enable, 0);
      check("err_resp_valid_fast", resp_valid, 1);
    end else begin
      check("acc_mem_enable", mem_enable, 1);
      check("acc_write_enable", mem_write_enable, op_store(op));
      check("acc_address", mem_address, addr >> 2);
      check("acc_data_type", mem_data_type, (size == 4) ? 2'b00 : (size == 2) ? 2'b01 : 2'b10);
      check("acc_input_data", mem_input_data, op_store(op) ? (wdata & size_mask(size)) : 32'h0);
      check("acc_req_ready", req_ready, 0);
      check("acc_resp_valid", resp_valid, 0);
      tick();
      check("resp_valid", resp_valid, 1);
      check("resp_mem_enable", mem_enable, 0);
    end
    check("resp_rdata", resp_rdata, exp_rdata);
    check("resp_error", resp_error, exp_error);
    if (exp_error) exp_err++;
    else if (op_store(op)) exp_store++;
    else exp_load++;
    tick();
    check("idle_resp_valid", resp_valid, 0);
    check("load_count", load_count, exp_load);
    check("store_count", store_count, exp_store);
    check("error_count", error_count, exp_err);
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_error;
    logic [31:0] exp_rdata;
  } vec_t;

  initial begin
    vec_t        vecs [12];
    logic        m_err;
    logic [31:0] m_rdata;

    vecs[0]  = '{SW,  32'h10,   32'hDEADBEEF, 1'b0, 32'h0};
    vecs[1]  = '{LW,  32'h10,   32'h0,        1'b0, 32'hDEADBEEF};
    vecs[2]  = '{SW,  32'h14,   32'h000080F0, 1'b0, 32'h0};
    vecs[3]  = '{LB,  32'h14,   32'h0,        1'b0, 32'hFFFFFFF0};
    vecs[4]  = '{LBU, 32'h14,   32'h0,        1'b0, 32'h000000F0};
    vecs[5]  = '{LH,  32'h14,   32'h0,        1'b0, 32'hFFFF80F0};
    vecs[6]  = '{LHU, 32'h14,   32'h0,        1'b0, 32'h000080F0};
    vecs[7]  = '{LW,  32'h12,   32'h0,        1'b1, 32'h0};
    vecs[8]  = '{SH,  32'h13,   32'h12345678, 1'b1, 32'h0};
    vecs[9]  = '{LW,  32'h2000, 32'h0,        1'b1, 32'h0};
    vecs[10] = '{SB,  32'h1FFF, 32'h555555AB, 1'b0, 32'h0};
    vecs[11] = '{LBU, 32'h1FFF, 32'h0,        1'b0, 32'h000000AB};

    for (int i = 0; i < DEPTH; i++) begin
      mem_phys[i] = 32'h0;
      ref_mem[i]  = 32'h0;
    end
    req_valid = 0; req_op = LW; req_addr = 0; req_wdata = 0; resp_ready = 1;
    s_req_valid = 0; s_req_op = SB; s_req_addr = 0; s_req_wdata = 0; s_resp_ready = 1;
    reset = 1;
    tick();
    tick();
    check("rst_req_ready", req_ready, 1);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_resp_rdata", resp_rdata, 0);
    check("rst_mem_enable", mem_enable, 0);
    check("rst_counts", {load_count, store_count}, 0);
    reset = 0;
    tick();

    // Directed vector table.
    for (int i = 0; i < 12; i++) begin
      ref_access(vecs[i].op, vecs[i].addr, vecs[i].wdata, m_err, m_rdata);
      do_req(vecs[i].op, vecs[i].addr, vecs[i].wdata, vecs[i].exp_error, vecs[i].exp_rdata);
    end

    // Reset in ACCESS of a store, before the falling edge.
    req_valid = 1; req_op = SW; req_addr = 32'h20; req_wdata = 32'h12345678; resp_ready = 1;
    tick();
    req_valid = 0;
    check("rstmid_in_access", mem_enable, 1);
    #1 reset = 1;
    #1;
    check("rstmid_mem_enable", mem_enable, 0);
    check("rstmid_write_enable", mem_write_enable, 0);
    check("rstmid_address", mem_address, 0);
    check("rstmid_req_ready", req_ready, 1);
    check("rstmid_resp_valid", resp_valid, 0);
    check("rstmid_store_count", store_count, 0);
    check("rstmid_error_count", error_count, 0);
    exp_load = 0; exp_store = 0; exp_err = 0;
    tick();
    reset = 0;
    check("rstmid_mem_word", mem_phys[8], ref_mem[8]);
    tick();
    do_req(LW, 32'h20, 32'h0, 1'b0, 32'h0);

    // Back-pressure: response held, new request ignored until IDLE.
    req_valid = 1; req_op = LW; req_addr = 32'h10; resp_ready = 0;
    tick();
    req_valid = 0;
    tick();
    for (int i = 0; i < 5; i++) begin
      check("bp_resp_valid", resp_valid, 1);
      check("bp_resp_rdata", resp_rdata, 32'hDEADBEEF);
      check("bp_req_ready", req_ready, 0);
      check("bp_mem_enable", mem_enable, 0);
      check("bp_load_count", load_count, exp_load);
      req_valid = 1; req_op = LBU; req_addr = 32'h14;
      tick();
    end
    resp_ready = 1;
    tick();
    exp_load++;
    check("bp_release_idle", req_ready, 1);
    check("bp_release_count", load_count, exp_load);
    tick();
    req_valid = 0;
    check("bp_pending_enable", mem_enable, 1);
    check("bp_pending_address", mem_address, 5);
    tick();
    check("bp_pending_rdata", resp_rdata, 32'h000000F0);
    tick();
    exp_load++;
    check("bp_pending_count", load_count, exp_load);

    // Randomized requests against the reference model.
    for (int n = 0; n < 200; n++) begin
      logic [2:0]  op;
      logic [31:0] addr, wdata;
      int          r;
      op    = 3'($urandom_range(0, 7));
      wdata = $urandom;
      r     = $urandom_range(0, 9);
      if (r == 0)      addr = DEPTH * 4 + $urandom_range(0, 7);
      else if (r == 1) addr = $urandom;
      else             addr = $urandom_range(0, 63);
      ref_access(op, addr, wdata, m_err, m_rdata);
      do_req(op, addr, wdata, m_err, m_rdata);
    end

    // Saturation of a 2-bit store counter after five stores.
    for (int i = 0; i < 5; i++) begin
      s_req_valid = 1; s_req_op = SB; s_req_addr = i; s_req_wdata = i; s_resp_ready = 1;
      tick();
      s_req_valid = 0;
      tick();
      tick();
      check("sat_store_count", s_store_count, (i + 1 > 3) ? 3 : i + 1);
    end
    check("sat_load_count", s_load_count, 0);
    check("sat_error_count", s_error_count, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
